glan_act_blinker: RTL and testbench



---
 rtl/glan_led_pkg.sv | 13 +
 rtl/glan_act_blink_ch.sv | 130 +++++++++++++
 rtl/glan_act_blinker.sv | 73 +++++++
 tb/tb_glan_act_blinker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/glan_led_pkg.sv
// Shared types and constants for the GLAN activity-LED blinker.
package glan_led_pkg;

  localparam int TIMER_W = 8;
  localparam logic LED_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_e;

endpackage

// File: rtl/glan_act_blink_ch.sv
// One activity-LED channel: ACT# synchroniser, IDLE/ON/OFF blink FSM,
// tick timer and single-entry pending flag.
module glan_act_blink_ch
  import glan_led_pkg::*;
#(
  parameter int ON_TICKS  = 50,
  parameter int OFF_TICKS = 50
) (
  input  logic SysClk,
  input  logic ResetN,
  input  logic act_in_n_i,
  input  logic tick_i,
  input  logic pg_s_i,
  output logic led_act_n_o,
  output logic busy_o
);

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_TICKS);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_TICKS);
  localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] T_ZERO   = TIMER_W'(0);

  logic               act_meta_q, act_sync_q;
  logic               act_s;
  blink_state_e       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pending_q, pending_d;
  logic               led_n_q, led_n_d;
  logic               busy_q, busy_d;

  // Two-flop synchroniser for the asynchronous active-low activity strobe
  always_ff @(posedge SysClk or negedge ResetN) begin
    if (!ResetN) begin
      act_meta_q <= 1'b1;
      act_sync_q <= 1'b1;
    end else begin
      act_meta_q <= act_in_n_i;
      act_sync_q <= act_meta_q;
    end
  end

  assign act_s = ~act_sync_q;

  // State, timer, pending and output registers
  always_ff @(posedge SysClk or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= IDLE;
      timer_q   <= T_ZERO;
      pending_q <= 1'b0;
      led_n_q   <= LED_OFF;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      led_n_q   <= led_n_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they
  // register together with it and keep the 3-cycle ACT#-to-LED latency
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    if (!pg_s_i) begin
      state_d   = IDLE;
      timer_d   = T_ZERO;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (act_s) begin
            state_d   = ON;
            timer_d   = ON_LOAD;
            pending_d = 1'b0;
          end else begin
            state_d   = IDLE;
          end
        end
        ON: begin
          pending_d = pending_q | act_s;
          if (tick_i) begin
            if (timer_q == T_ONE) begin
              state_d = OFF;
              timer_d = OFF_LOAD;
            end else begin
              timer_d = timer_q - T_ONE;
            end
          end else begin
            timer_d = timer_q;
          end
        end
        OFF: begin
          if (tick_i && (timer_q == T_ONE)) begin
            // Activity on the expiry cycle itself still earns a re-blink
            if (pending_q || act_s) begin
              state_d   = ON;
              timer_d   = ON_LOAD;
              pending_d = 1'b0;
            end else begin
              state_d   = IDLE;
              timer_d   = T_ZERO;
              pending_d = 1'b0;
            end
          end else begin
            pending_d = pending_q | act_s;
            if (tick_i) begin
              timer_d = timer_q - T_ONE;
            end else begin
              timer_d = timer_q;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          timer_d   = T_ZERO;
          pending_d = 1'b0;
        end
      endcase
    end
    led_n_d = (state_d == ON) ? ~LED_OFF : LED_OFF;
    busy_d  = (state_d != IDLE);
  end

  assign led_act_n_o = led_n_q;
  assign busy_o      = busy_q;

endmodule

// File: rtl/glan_act_blinker.sv
// Activity-LED pulse shaper for the 2-port GLAN board: shared ms prescaler,
// power-good synchroniser and one blink channel per port.
module glan_act_blinker
  import glan_led_pkg::*;
#(
  parameter int PORTS     = 2,
  parameter int TICK_DIV  = 33000,
  parameter int ON_TICKS  = 50,
  parameter int OFF_TICKS = 50
) (
  input  logic             SysClk,
  input  logic             ResetN,
  input  logic             ALL_PWRGD,
  input  logic [PORTS-1:0] ActInN,
  output logic [PORTS-1:0] LedActN,
  output logic [PORTS-1:0] Busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_s;
  logic             pg_meta_q, pg_sync_q;

  // Free-running timebase prescaler
  always_ff @(posedge SysClk or negedge ResetN) begin
    if (!ResetN) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick on terminal count, then wrap
  always_comb begin
    tick_s = (cnt_q == CNT_MAX);
    if (tick_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Two-flop synchroniser for power-good; resets to "power not good"
  always_ff @(posedge SysClk or negedge ResetN) begin
    if (!ResetN) begin
      pg_meta_q <= 1'b0;
      pg_sync_q <= 1'b0;
    end else begin
      pg_meta_q <= ALL_PWRGD;
      pg_sync_q <= pg_meta_q;
    end
  end

  for (genvar i = 0; i < PORTS; i++) begin : g_ch
    glan_act_blink_ch #(
      .ON_TICKS  (ON_TICKS),
      .OFF_TICKS (OFF_TICKS)
    ) u_ch (
      .SysClk      (SysClk),
      .ResetN      (ResetN),
      .act_in_n_i  (ActInN[i]),
      .tick_i      (tick_s),
      .pg_s_i      (pg_sync_q),
      .led_act_n_o (LedActN[i]),
      .busy_o      (Busy[i])
    );
  end

endmodule

// File: tb/tb_glan_act_blinker.sv
// Directed bench for glan_act_blinker with TICK_DIV=4, ON_TICKS=3, OFF_TICKS=2.
module tb_glan_act_blinker;

  logic       SysClk = 1'b0;
  logic       ResetN;
  logic       ALL_PWRGD;
  logic [1:0] ActInN;
  logic [1:0] LedActN;
  logic [1:0] Busy;

  int total = 0;
  int bad   = 0;

  logic mon_en   = 1'b0;
  int   mon_port = 0;
  logic mon_bad  = 1'b0;

  glan_act_blinker #(
    .PORTS     (2),
    .TICK_DIV  (4),
    .ON_TICKS  (3),
    .OFF_TICKS (2)
  ) dut (
    .SysClk    (SysClk),
    .ResetN    (ResetN),
    .ALL_PWRGD (ALL_PWRGD),
    .ActInN    (ActInN),
    .LedActN   (LedActN),
    .Busy      (Busy)
  );

  always #5 SysClk = ~SysClk;

  // Watches the port that must stay idle during a scenario
  always @(negedge SysClk) begin
    if (mon_en && (LedActN[mon_port] !== 1'b1 || Busy[mon_port] !== 1'b0)) begin
      mon_bad <= 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge SysClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles for which port p stays at the given LED/busy pair
  task automatic measure(input int p, input logic led, input logic busy, output int n);
    n = 0;
    while (LedActN[p] === led && Busy[p] === busy && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic pulse0();
    ActInN[0] = 1'b0;
    step();
    ActInN[0] = 1'b1;
  endtask

  initial begin
    int  n, n2, n3, n4, cyc;
    logic ok;

    ResetN    = 1'b0;
    ALL_PWRGD = 1'b1;
    ActInN    = 2'b11;
    repeat (3) step();
    chk("rst_led", LedActN, 2'b11);
    chk("rst_busy", Busy, 2'b00);
    ResetN = 1'b1;
    repeat (4) step();

    // 1: asynchronous reset in the middle of a blink
    pulse0();
    step();
    step();
    chk("s1_led_on", LedActN[0], 1'b0);
    step();
    step();
    ResetN = 1'b0;
    #1;
    chk("s1_async_led", LedActN, 2'b11);
    chk("s1_async_busy", Busy, 2'b00);
    step();
    ResetN = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (LedActN !== 2'b11 || Busy !== 2'b00) ok = 1'b0;
    end
    chk("s1_stay_idle", ok, 1'b1);

    // 2: single pulse, exact latency and interval lengths
    mon_port = 1;
    mon_bad  = 1'b0;
    mon_en   = 1'b1;
    ActInN[0] = 1'b0;
    step();
    ActInN[0] = 1'b1;
    step();
    chk("s2_lat2_still_off", LedActN[0], 1'b1);
    step();
    chk("s2_lat3_on", LedActN[0], 1'b0);
    chk("s2_busy", Busy[0], 1'b1);
    measure(0, 1'b0, 1'b1, n);
    chk("s2_on_len_9_12", (n >= 9 && n <= 12), 1'b1);
    measure(0, 1'b1, 1'b1, n);
    chk("s2_off_len_5_8", (n >= 5 && n <= 8), 1'b1);
    chk("s2_idle", Busy[0], 1'b0);
    mon_en = 1'b0;
    chk("s2_port1_quiet", mon_bad, 1'b0);

    // 3a: one pulse during ON queues exactly one more blink
    pulse0();
    step();
    step();
    chk("s3_lat", LedActN[0], 1'b0);
    step();
    pulse0();
    measure(0, 1'b0, 1'b1, n);
    chk("s3_on1_len", (2 + n >= 9 && 2 + n <= 12), 1'b1);
    measure(0, 1'b1, 1'b1, n);
    chk("s3_off1_len", (n >= 5 && n <= 8), 1'b1);
    chk("s3_reblink", LedActN[0], 1'b0);
    measure(0, 1'b0, 1'b1, n);
    chk("s3_on2_len", n, 32'd12);
    measure(0, 1'b1, 1'b1, n);
    chk("s3_off2_len", n, 32'd8);
    chk("s3_idle", Busy[0], 1'b0);

    // 3b: two pulses during ON still yield only one extra blink
    pulse0();
    step();
    step();
    chk("s3b_lat", LedActN[0], 1'b0);
    step();
    pulse0();
    step();
    step();
    pulse0();
    measure(0, 1'b0, 1'b1, n);
    chk("s3b_on1_len", (5 + n >= 9 && 5 + n <= 12), 1'b1);
    measure(0, 1'b1, 1'b1, n);
    chk("s3b_reblink", LedActN[0], 1'b0);
    measure(0, 1'b0, 1'b1, n);
    measure(0, 1'b1, 1'b1, n);
    chk("s3b_no_third", Busy[0], 1'b0);

    // 4: continuous activity on port 1 gives a steady blink train
    mon_port = 0;
    mon_bad  = 1'b0;
    mon_en   = 1'b1;
    ActInN[1] = 1'b0;
    repeat (3) step();
    chk("s4_lat", LedActN[1], 1'b0);
    measure(1, 1'b0, 1'b1, n);
    measure(1, 1'b1, 1'b1, n2);
    cyc = 3 + n + n2;
    measure(1, 1'b0, 1'b1, n3);
    measure(1, 1'b1, 1'b1, n4);
    cyc += n3 + n4;
    chk("s4_period1", (n3 + n4 >= 16 && n3 + n4 <= 24), 1'b1);
    measure(1, 1'b0, 1'b1, n3);
    measure(1, 1'b1, 1'b1, n4);
    cyc += n3 + n4;
    chk("s4_period2", (n3 + n4 >= 16 && n3 + n4 <= 24), 1'b1);
    while (cyc < 200) begin
      step();
      cyc++;
    end
    ActInN[1] = 1'b1;
    n = 0;
    while (Busy[1] !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    chk("s4_drain", Busy[1], 1'b0);
    mon_en = 1'b0;
    chk("s4_port0_quiet", mon_bad, 1'b0);

    // 5: power-good drop mid-blink, ignored activity, then recovery
    pulse0();
    step();
    step();
    chk("s5_on", LedActN[0], 1'b0);
    step();
    step();
    ALL_PWRGD = 1'b0;
    step();
    step();
    chk("s5_pg_lat2", LedActN[0], 1'b0);
    step();
    chk("s5_pg_led", LedActN, 2'b11);
    chk("s5_pg_busy", Busy, 2'b00);
    ok = 1'b1;
    ActInN = 2'b00;
    for (int i = 0; i < 15; i++) begin
      if (i == 5) ActInN = 2'b11;
      step();
      if (LedActN !== 2'b11 || Busy !== 2'b00) ok = 1'b0;
    end
    chk("s5_hold_off", ok, 1'b1);
    ALL_PWRGD = 1'b1;
    repeat (4) step();
    pulse0();
    step();
    step();
    chk("s5_resume", LedActN[0], 1'b0);
    measure(0, 1'b0, 1'b1, n);
    chk("s5_on_len", (n >= 9 && n <= 12), 1'b1);
    measure(0, 1'b1, 1'b1, n);
    chk("s5_idle", Busy[0], 1'b0);

    // 6: activity lands exactly on the OFF-expiry tick
    pulse0();
    step();
    step();
    measure(0, 1'b0, 1'b1, n);
    chk("s6_in_off", {LedActN[0], Busy[0]}, 2'b11);
    repeat (5) step();
    pulse0();
    step();
    chk("s6_pre_expiry", {LedActN[0], Busy[0]}, 2'b11);
    step();
    chk("s6_direct_on", {LedActN[0], Busy[0]}, 2'b01);
    measure(0, 1'b0, 1'b1, n);
    chk("s6_on_len", n, 32'd12);
    measure(0, 1'b1, 1'b1, n);
    chk("s6_off_len", n, 32'd8);
    chk("s6_idle", Busy[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
